// File: rtl/add_result_pkg.sv
// Shared types and constants for the 64-bit adder result buffer.
package add_result_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned DEPTH  = 2;

    typedef struct packed {
        logic [DATA_W-1:0] sum;
        logic              cout;
        logic              ovf;
    } add_result_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

endpackage

// File: rtl/add_ovf_stat.sv
// Signed-overflow detection and saturating overflow-event counter.
// Optional feature macro: ADD_RESULT_BUFFER_STATS_EN (enables the counter).
module add_ovf_stat (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_msb,
    input  logic        b_msb,
    input  logic        sum_msb,
    input  logic        push,
    output logic        ovf,
    output logic [15:0] ovf_count
);

    // Operands of equal sign producing a result of the opposite sign.
    always_comb begin
        ovf = (a_msb == b_msb) && (sum_msb != a_msb);
    end

`ifdef ADD_RESULT_BUFFER_STATS_EN
    logic [15:0] ovf_count_q;
    logic [15:0] ovf_count_d;

    // Count accepted overflow results, holding at all-ones.
    always_comb begin
        ovf_count_d = ovf_count_q;
        if (push && ovf && (ovf_count_q != 16'hFFFF)) begin
            ovf_count_d = ovf_count_q + 16'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_count_q <= '0;
        end else begin
            ovf_count_q <= ovf_count_d;
        end
    end

    assign ovf_count = ovf_count_q;
`else
    logic unused_stat_inputs;

    assign ovf_count          = 16'h0000;
    assign unused_stat_inputs = &{1'b0, clk, rst_n, push};
`endif

endmodule

// File: rtl/add_result_buffer_64.sv
// Two-entry result FIFO behind a 64-bit full adder: stores {sum, cout, ovf}.
// Optional feature macro: ADD_RESULT_BUFFER_STATS_EN (overflow event counter).
module add_result_buffer_64
    import add_result_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] sum,
    input  logic        cout,
    input  logic        a_msb,
    input  logic        b_msb,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_sum,
    output logic        out_cout,
    output logic        out_ovf,
    output logic [15:0] ovf_count
);

    localparam logic [1:0] ST_EMPTY = EMPTY;
    localparam logic [1:0] ST_ONE   = ONE;
    localparam logic [1:0] ST_FULL  = FULL;

    logic [1:0]  state_q;
    logic [1:0]  state_d;
    logic        wr_ptr_q;
    logic        wr_ptr_d;
    logic        rd_ptr_q;
    logic        rd_ptr_d;
    add_result_t mem_q [DEPTH];
    add_result_t mem_d [DEPTH];

    logic        push;
    logic        pop;
    logic        ovf;
    add_result_t head;

    add_ovf_stat u_ovf_stat (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_msb     (a_msb),
        .b_msb     (b_msb),
        .sum_msb   (sum[63]),
        .push      (push),
        .ovf       (ovf),
        .ovf_count (ovf_count)
    );

    // Handshake flags derived from registered state only.
    always_comb begin
        in_ready  = (state_q != ST_FULL);
        out_valid = (state_q != ST_EMPTY);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
    end

    // Next-state, pointer and storage update.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;

        if (push) begin
            mem_d[wr_ptr_q] = '{sum: sum, cout: cout, ovf: ovf};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case (state_q)
            ST_EMPTY: begin
                if (push) state_d = ST_ONE;
            end
            ST_ONE: begin
                if (push && !pop)      state_d = ST_FULL;
                else if (pop && !push) state_d = ST_EMPTY;
                else                   state_d = ST_ONE;
            end
            ST_FULL: begin
                if (pop) state_d = ST_ONE;
            end
            default: begin
                state_d  = ST_EMPTY;
                wr_ptr_d = 1'b0;
                rd_ptr_d = 1'b0;
            end
        endcase
    end

    // State, pointers and storage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

    // Head entry presented only while valid; zeros otherwise.
    always_comb begin
        head     = mem_q[rd_ptr_q];
        out_sum  = out_valid ? head.sum  : '0;
        out_cout = out_valid ? head.cout : 1'b0;
        out_ovf  = out_valid ? head.ovf  : 1'b0;
    end

endmodule

// File: tb/tb_add_result_buffer_64.sv
// Scoreboard bench for add_result_buffer_64.
module tb_add_result_buffer_64;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] sum;
    logic        cout;
    logic        a_msb;
    logic        b_msb;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_sum;
    logic        out_cout;
    logic        out_ovf;
    logic [15:0] ovf_count;

    int          n_tests;
    int          n_fail;
    logic [65:0] exp_q [$];
    logic [15:0] exp_cnt;

    add_result_buffer_64 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum       (sum),
        .cout      (cout),
        .a_msb     (a_msb),
        .b_msb     (b_msb),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .ovf_count (ovf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Pops the scoreboard whenever the DUT hands over its head entry.
    task automatic monitor();
        logic [65:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %h expected none", {out_sum, out_cout, out_ovf});
                end else begin
                    e = exp_q.pop_front();
                    check("output_entry", {out_sum, out_cout, out_ovf}, e);
                end
            end
        end
    endtask

    // Presents one result for one cycle; records it if the DUT accepts it.
    task automatic do_push(input logic [63:0] s, input logic c, input logic am,
                           input logic bm, input logic eo, input logic chk_pt);
        sum      = s;
        cout     = c;
        a_msb    = am;
        b_msb    = bm;
        in_valid = 1'b1;
        if (chk_pt) begin
            #1;
            check("no_pass_through", {65'd0, out_valid}, 66'd0);
        end
        @(negedge clk);
        if (in_ready) begin
            exp_q.push_back({s, c, eo});
`ifdef ADD_RESULT_BUFFER_STATS_EN
            if (eo && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
`endif
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
        end
        #1;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        exp_cnt   = 16'h0000;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sum       = '0;
        cout      = 1'b0;
        a_msb     = 1'b0;
        b_msb     = 1'b0;
        fork
            monitor();
        join_none

        // Reset values.
        #3;
        check("rst_out_valid", {65'd0, out_valid}, 66'd0);
        check("rst_in_ready",  {65'd0, in_ready}, 66'd1);
        check("rst_out_fields", {out_sum, out_cout, out_ovf}, 66'd0);
        check("rst_ovf_count", {50'd0, ovf_count}, 66'd0);
        #9;
        rst_n = 1'b1;
        idle(1);

        // Single push with the consumer ready: latency 1, then empty again.
        out_ready = 1'b1;
        do_push(64'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("latency_out_valid", {65'd0, out_valid}, 66'd1);
        check("latency_out_sum", {2'b0, out_sum}, {2'b0, 64'h1});
        idle(1);
        check("drained_out_valid", {65'd0, out_valid}, 66'd0);
        check("drained_zero_fields", {out_sum, out_cout, out_ovf}, 66'd0);

        // Signed-overflow classification on hand-worked operand sign cases.
        do_push(64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        do_push(64'h0000_0000_0000_0005, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        do_push(64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        do_push(64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        do_push(64'h8000_0000_0000_0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
`ifdef ADD_RESULT_BUFFER_STATS_EN
        check("ovf_count_two", {50'd0, ovf_count}, 66'd2);
`else
        check("ovf_count_tied", {50'd0, ovf_count}, 66'd0);
`endif
        check("ovf_count_model", {50'd0, ovf_count}, {50'd0, exp_cnt});

        // Back-pressure: fill, third push ignored, hold stable, drain in order.
        out_ready = 1'b0;
        do_push(64'hA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_push(64'hB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("full_in_ready", {65'd0, in_ready}, 66'd0);
        do_push(64'hC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("hold_head_1", {out_sum, out_cout, out_ovf}, {64'hA, 2'b00});
        idle(1);
        check("hold_head_2", {out_sum, out_cout, out_ovf}, {64'hA, 2'b00});
        out_ready = 1'b1;
        idle(3);
        check("after_drain_empty", {65'd0, out_valid}, 66'd0);

        // Simultaneous push and pop in ONE: new entry becomes head.
        out_ready = 1'b0;
        do_push(64'hA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        do_push(64'hB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("pp_one_in_ready", {65'd0, in_ready}, 66'd1);
        check("pp_one_out_valid", {65'd0, out_valid}, 66'd1);
        check("pp_new_head", {2'b0, out_sum}, {2'b0, 64'hB});
        idle(2);
        check("pp_drained", {65'd0, out_valid}, 66'd0);

        // Asynchronous reset while FULL discards everything.
        out_ready = 1'b0;
        do_push(64'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_push(64'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("pre_reset_full", {65'd0, in_ready}, 66'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", {65'd0, out_valid}, 66'd0);
        check("async_rst_fields", {out_sum, out_cout, out_ovf}, 66'd0);
        check("async_rst_count", {50'd0, ovf_count}, 66'd0);
        exp_q.delete();
        exp_cnt = 16'h0000;
        #3;
        rst_n = 1'b1;
        idle(1);
        check("post_rst_in_ready", {65'd0, in_ready}, 66'd1);
        check("post_rst_out_valid", {65'd0, out_valid}, 66'd0);

        // Overflow counter saturation (or staying tied off).
        out_ready = 1'b1;
`ifdef ADD_RESULT_BUFFER_STATS_EN
        for (int i = 0; i < 65540; i++) begin
            do_push(64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        idle(2);
        check("ovf_count_saturated", {50'd0, ovf_count}, {50'd0, 16'hFFFF});
`else
        for (int i = 0; i < 8; i++) begin
            do_push(64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        idle(2);
        check("ovf_count_still_zero", {50'd0, ovf_count}, 66'd0);
`endif
        check("sat_model", {50'd0, ovf_count}, {50'd0, exp_cnt});
        check("scoreboard_empty", 66'(exp_q.size()), 66'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
